// File: rtl/bip_datapath.sv
// BIP execution datapath: accumulator, sign extension, add/sub ALU,
// data-memory port and a read sequencer that stalls the control unit
// while a memory read is outstanding.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   operand                immediate / data address (instruction[10:0])
//   SelA, SelB, WrAcc, Op  accumulator source, ALU B source, load, add/sub
//   WrRam, RdRam           store / load strobes from the control unit
//   stall                  hold PC and instruction (combinational)
//   mem_addr/wdata/we/re   data-memory request side (combinational)
//   mem_rdata/rvalid       data-memory response side
//   acc, flag_z/n/v, err   accumulator, status flags, sticky protocol error
module bip_datapath #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned RD_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] operand,
  input  logic [1:0]        SelA,
  input  logic              SelB,
  input  logic              WrAcc,
  input  logic              Op,
  input  logic              WrRam,
  input  logic              RdRam,
  output logic              stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic [DATA_W-1:0] acc,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_v,
  output logic              err
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t              state, state_d;
  logic [DATA_W-1:0]   acc_d;
  logic                flag_z_d, flag_n_d, flag_v_d, err_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    cnt, cnt_d;

  logic [DATA_W-1:0]   imm;
  logic [DATA_W-1:0]   mdata;
  logic [DATA_W-1:0]   alu_b;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_v;
  logic                load_en;

  // Sign-extend the operand to the datapath width.
  assign imm = {{(DATA_W-ADDR_W){operand[ADDR_W-1]}}, operand};

  // Store data is always the accumulator value before this cycle's load.
  assign mem_wdata = acc;

  // Add/sub ALU with signed-overflow detection (wraps modulo 2^DATA_W).
  always_comb begin
    alu_b   = SelB ? imm : mdata;
    alu_res = Op ? (acc - alu_b) : (acc + alu_b);
    if (Op) alu_v = (acc[DATA_W-1] != alu_b[DATA_W-1]) && (alu_res[DATA_W-1] != acc[DATA_W-1]);
    else    alu_v = (acc[DATA_W-1] == alu_b[DATA_W-1]) && (alu_res[DATA_W-1] != acc[DATA_W-1]);
  end

  // Next-state, accumulator load and memory strobes.
  always_comb begin
    state_d  = state;
    acc_d    = acc;
    flag_z_d = flag_z;
    flag_n_d = flag_n;
    flag_v_d = flag_v;
    err_d    = err;
    addr_d   = addr_q;
    cnt_d    = cnt;
    stall    = 1'b0;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    mem_addr = operand;
    mdata    = '0;
    load_en  = 1'b0;

    case (state)
      ST_IDLE: begin
        // A response with no read outstanding is a protocol error.
        if (mem_rvalid) err_d = 1'b1;
        if (WrRam) begin
          // Store wins over a simultaneous read; the read is dropped.
          mem_we  = 1'b1;
          load_en = WrAcc;
          if (RdRam) err_d = 1'b1;
        end else if (RdRam) begin
          // Issue the read; the load is deferred until data returns.
          mem_re  = 1'b1;
          stall   = 1'b1;
          addr_d  = operand;
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else begin
          load_en = WrAcc;
        end
      end
      ST_WAIT: begin
        stall    = 1'b1;
        mem_addr = addr_q;
        if (mem_rvalid) begin
          stall   = 1'b0;
          mdata   = mem_rdata;
          load_en = WrAcc;
          state_d = ST_IDLE;
        end else if ((RD_TIMEOUT != 0) && (cnt >= CNT_W'(RD_TIMEOUT - 1))) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_en) begin
      if (SelA == 2'd3) begin
        err_d = 1'b1;
      end else begin
        case (SelA)
          2'd0:    acc_d = mdata;
          2'd1:    acc_d = imm;
          default: acc_d = alu_res;
        endcase
        flag_z_d = (acc_d == '0);
        flag_n_d = acc_d[DATA_W-1];
        flag_v_d = (SelA == 2'd2) ? alu_v : 1'b0;
      end
    end

    // Memory port and stall are quiet while reset is asserted.
    if (rst) begin
      stall    = 1'b0;
      mem_we   = 1'b0;
      mem_re   = 1'b0;
      mem_addr = '0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      acc    <= '0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_v <= 1'b0;
      err    <= 1'b0;
      addr_q <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_d;
      acc    <= acc_d;
      flag_z <= flag_z_d;
      flag_n <= flag_n_d;
      flag_v <= flag_v_d;
      err    <= err_d;
      addr_q <= addr_d;
      cnt    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bip_datapath.sv
// Self-checking bench for bip_datapath: per-scenario tasks, expected
// accumulator values queued when a load is issued and popped on completion.
module tb_bip_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] operand;
  logic [1:0]  SelA;
  logic        SelB, WrAcc, Op, WrRam, RdRam;
  logic        stall;
  logic [10:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we, mem_re;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;
  logic [15:0] acc;
  logic        flag_z, flag_n, flag_v, err;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];
  logic [15:0] m_acc;
  logic [15:0] exp_v;

  always #5 clk = ~clk;

  bip_datapath #(.DATA_W(16), .ADDR_W(11), .RD_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .operand(operand), .SelA(SelA), .SelB(SelB),
    .WrAcc(WrAcc), .Op(Op), .WrRam(WrRam), .RdRam(RdRam), .stall(stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .acc(acc),
    .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v), .err(err)
  );

  // Reference ALU: returns {overflow, result}.
  function automatic logic [16:0] ref_alu(input logic [15:0] a, input logic [15:0] b, input logic sub);
    logic [15:0] r;
    logic        v;
    r = sub ? a - b : a + b;
    v = sub ? ((a[15] != b[15]) && (r[15] != a[15])) : ((a[15] == b[15]) && (r[15] != a[15]));
    return {v, r};
  endfunction

  function automatic logic [15:0] sext(input logic [10:0] x);
    return {{5{x[10]}}, x};
  endfunction

  task automatic set_ctrl(input logic [1:0] sa, input logic sb, input logic wa, input logic op,
                          input logic wr, input logic rd, input logic [10:0] opd);
    SelA = sa; SelB = sb; WrAcc = wa; Op = op; WrRam = wr; RdRam = rd; operand = opd;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; mem_rvalid = 1'b0;
    set_ctrl(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_acc = 16'h0;
    exp_q.delete();
  endtask

  // Memory load with response 'lat' cycles after the request; queues expected acc.
  task automatic mem_load(input logic [15:0] data, input int lat);
    @(negedge clk);
    set_ctrl(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'h010);
    exp_q.push_back(data);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      mem_rvalid = (k == lat);
      mem_rdata  = data;
    end
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      failures++; $display("FAIL mem_load_queue empty");
    end else begin
      exp_v = exp_q.pop_front(); checks++;
      if (acc !== exp_v) begin failures++; $display("FAIL mem_load_acc actual=%h required=%h", acc, exp_v); end
    end
    m_acc = data;
    @(negedge clk);
    mem_rvalid = 1'b0;
    set_ctrl(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h0);
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_rvalid = 1'b0; mem_rdata = 16'h0;
    set_ctrl(2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 11'h123);
    @(negedge clk); #1;
    checks++;
    if ({stall, mem_we, mem_re} !== 3'b000) begin failures++; $display("FAIL reset_strobes actual=%b required=000", {stall, mem_we, mem_re}); end
    checks++;
    if (mem_addr !== 11'h0) begin failures++; $display("FAIL reset_addr actual=%h required=000", mem_addr); end
    @(posedge clk); #1;
    checks++;
    if ({acc, flag_z, flag_n, flag_v, err} !== 20'h0) begin
      failures++; $display("FAIL reset_state acc=%h z=%b n=%b v=%b err=%b required all zero", acc, flag_z, flag_n, flag_v, err);
    end
    apply_reset();
  endtask

  task automatic test_ldi();
    @(negedge clk);
    set_ctrl(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h7FF);
    exp_q.push_back(16'hFFFF);
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL ldi_stall actual=%b required=0", stall); end
    @(posedge clk); #1;
    exp_v = exp_q.pop_front(); checks++;
    if (acc !== exp_v) begin failures++; $display("FAIL ldi_acc actual=%h required=%h", acc, exp_v); end
    checks++;
    if ({flag_n, flag_z} !== 2'b10) begin failures++; $display("FAIL ldi_flags n,z actual=%b required=10", {flag_n, flag_z}); end
    m_acc = 16'hFFFF;
  endtask

  task automatic test_addi_subi();
    mem_load(16'h7FFF, 1);
    @(negedge clk);
    set_ctrl(2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'h001);
    exp_q.push_back(16'h8000);
    @(posedge clk); #1;
    exp_v = exp_q.pop_front(); checks++;
    if ({acc, flag_v, flag_n} !== {exp_v, 2'b11}) begin failures++; $display("FAIL addi acc=%h v=%b n=%b required=%h v=1 n=1", acc, flag_v, flag_n, exp_v); end
    @(negedge clk);
    set_ctrl(2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 11'h001);
    exp_q.push_back(16'h7FFF);
    @(posedge clk); #1;
    exp_v = exp_q.pop_front(); checks++;
    if ({acc, flag_v} !== {exp_v, 1'b1}) begin failures++; $display("FAIL subi acc=%h v=%b required=%h v=1", acc, flag_v, exp_v); end
    m_acc = 16'h7FFF;
  endtask

  task automatic test_ld_latency();
    int stalls = 0;
    int reqs   = 0;
    @(negedge clk);
    set_ctrl(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'h010);
    exp_q.push_back(16'h1234);
    #1;
    stalls += int'(stall); reqs += int'(mem_re);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      mem_rvalid = (k == 3);
      mem_rdata  = 16'h1234;
      #1;
      stalls += int'(stall); reqs += int'(mem_re);
      if (k == 2) begin
        checks++;
        if (mem_addr !== 11'h010) begin failures++; $display("FAIL ld_wait_addr actual=%h required=010", mem_addr); end
      end
    end
    @(posedge clk); #1;
    exp_v = exp_q.pop_front(); checks++;
    if (acc !== exp_v) begin failures++; $display("FAIL ld_acc actual=%h required=%h", acc, exp_v); end
    checks++;
    if (stalls != 3) begin failures++; $display("FAIL ld_stall_cycles actual=%0d required=3", stalls); end
    checks++;
    if (reqs != 1) begin failures++; $display("FAIL ld_re_pulses actual=%0d required=1", reqs); end
    m_acc = 16'h1234;
    @(negedge clk);
    mem_rvalid = 1'b0;
    set_ctrl(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h0);
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL ld_after_stall actual=%b required=0", stall); end
  endtask

  task automatic test_sto();
    mem_load(16'hBEEF, 2);
    @(negedge clk);
    set_ctrl(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'h005);
    #1;
    checks++;
    if ({mem_we, stall, mem_addr, mem_wdata} !== {1'b1, 1'b0, 11'h005, 16'hBEEF}) begin
      failures++; $display("FAIL sto we=%b stall=%b addr=%h wdata=%h required we=1 stall=0 addr=005 wdata=beef", mem_we, stall, mem_addr, mem_wdata);
    end
    @(negedge clk);
    set_ctrl(2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 11'h001);
    exp_q.push_back(16'h0001);
    #1;
    checks++;
    if (mem_wdata !== 16'hBEEF) begin failures++; $display("FAIL sto_ld_wdata actual=%h required=beef", mem_wdata); end
    @(posedge clk); #1;
    exp_v = exp_q.pop_front(); checks++;
    if (acc !== exp_v) begin failures++; $display("FAIL sto_ld_acc actual=%h required=%h", acc, exp_v); end
    m_acc = 16'h0001;
    @(negedge clk);
    set_ctrl(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h0);
    #1;
    checks++;
    if (mem_we !== 1'b0) begin failures++; $display("FAIL sto_we_single actual=%b required=0", mem_we); end
  endtask

  task automatic test_timeout();
    @(negedge clk);
    set_ctrl(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'h020);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); #1;
      checks++;
      if (stall !== 1'b1) begin failures++; $display("FAIL timeout_wait_stall cycle=%0d actual=%b required=1", k, stall); end
    end
    @(negedge clk);
    set_ctrl(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h0);
    #1;
    checks++;
    if ({stall, err} !== 2'b01) begin failures++; $display("FAIL timeout_end stall=%b err=%b required stall=0 err=1", stall, err); end
    checks++;
    if (acc !== m_acc) begin failures++; $display("FAIL timeout_acc actual=%h required=%h", acc, m_acc); end
    apply_reset();
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    set_ctrl(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h005);
    @(negedge clk);
    set_ctrl(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'h030);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_ctrl(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h0);
    mem_rvalid = 1'b1; mem_rdata = 16'h1234;
    exp_q.push_back(16'h0000);
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL rst_wait_stall actual=%b required=0", stall); end
    @(posedge clk); #1;
    exp_v = exp_q.pop_front(); checks++;
    if (acc !== exp_v) begin failures++; $display("FAIL rst_wait_acc actual=%h required=%h", acc, exp_v); end
    apply_reset();
  endtask

  task automatic test_conflict();
    @(negedge clk);
    set_ctrl(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 11'h007);
    #1;
    checks++;
    if ({mem_we, mem_re, stall} !== 3'b100) begin failures++; $display("FAIL conflict_strobes we,re,stall actual=%b required=100", {mem_we, mem_re, stall}); end
    @(negedge clk);
    set_ctrl(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h0);
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL conflict_err_sticky actual=%b required=1", err); end
    apply_reset();
    #1;
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL conflict_err_cleared actual=%b required=0", err); end
    // Reserved accumulator source: acc and flags hold, err set.
    set_ctrl(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h00A);
    @(negedge clk);
    set_ctrl(2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'h003);
    @(posedge clk); #1;
    checks++;
    if ({acc, err} !== {16'h000A, 1'b1}) begin failures++; $display("FAIL sela3 acc=%h err=%b required acc=000a err=1", acc, err); end
    apply_reset();
  endtask

  task automatic test_back_to_back();
    logic [16:0] r;
    logic [10:0] opd;
    logic [1:0]  sa;
    logic        op;
    logic        m_v;
    m_acc = 16'h0;
    for (int i = 0; i < 24; i++) begin
      opd = 11'($urandom);
      sa  = ($urandom_range(0, 3) == 0) ? 2'd1 : 2'd2;
      op  = 1'($urandom);
      @(negedge clk);
      set_ctrl(sa, 1'b1, 1'b1, op, 1'b0, 1'b0, opd);
      if (sa == 2'd1) begin
        m_acc = sext(opd); m_v = 1'b0;
      end else begin
        r = ref_alu(m_acc, sext(opd), op);
        m_acc = r[15:0]; m_v = r[16];
      end
      exp_q.push_back(m_acc);
      @(posedge clk); #1;
      exp_v = exp_q.pop_front(); checks++;
      if ({acc, flag_v, flag_z, flag_n} !== {exp_v, m_v, (exp_v == 16'h0), exp_v[15]}) begin
        failures++;
        $display("FAIL b2b[%0d] acc=%h v=%b z=%b n=%b required acc=%h v=%b", i, acc, flag_v, flag_z, flag_n, exp_v, m_v);
      end
    end
    @(negedge clk);
    set_ctrl(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h0);
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_addi_subi();
    test_ld_latency();
    test_sto();
    test_timeout();
    test_reset_in_wait();
    test_conflict();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
